// File: rtl/cnn_pkg.sv
// Shared CNN sequencing definitions: default frame geometry, data widths
// and the sequencer state encoding used by the conv and pool sequencers.
package cnn_pkg;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 5;
  localparam int PP    = 8;
  localparam int OP    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/raster_cnt.sv
// Column/row raster counter. Advances one position per enable, wraps the
// column into the next row and wraps the whole frame back to (0,0).
// 'last' flags the final position (H-1, W-1) of the frame.
module raster_cnt #(
  parameter int W  = 32,
  parameter int H  = 32,
  parameter int CW = $clog2(W) + 1,
  parameter int RW = $clog2(H) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_reg == CW'(W - 1));
  assign row_end = (row_reg == RW'(H - 1));

  // Position register: column steps every enable, row steps on column wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (en) begin
      if (col_end) begin
        col_reg <= '0;
        row_reg <= row_end ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  assign col  = col_reg;
  assign row  = row_reg;
  assign last = col_end && row_end;

endmodule

// File: rtl/conv_frame_seq.sv
// Frame sequencer for the first conv layer: streams one raster frame from
// pixel memory into the conv layer, pads with zero pixels until the conv
// pipeline drains, and forwards only results whose window is fully inside
// the frame. A zero-pixel cap guarantees completion even if the conv hangs.
module conv_frame_seq #(
  parameter int IMG_W = cnn_pkg::IMG_W,
  parameter int IMG_H = cnn_pkg::IMG_H,
  parameter int K     = cnn_pkg::K,
  parameter int PP    = cnn_pkg::PP,
  parameter int OP    = cnn_pkg::OP,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [PP:0]   mem_data,
  output logic [PP:0]   pxl_out,
  output logic          pxl_en,
  input  logic [OP:0]   conv_in,
  input  logic          conv_valid,
  output logic [OP:0]   out_data,
  output logic          out_valid
);

  import cnn_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(IMG_W) + 1;
  localparam int RW   = $clog2(IMG_H) + 1;
  localparam int ZW   = $clog2(NPIX + 1) + 1;

  seq_state_t    state_reg;
  seq_state_t    state_next;

  logic [CW-1:0] fetch_col;
  logic [RW-1:0] fetch_row;
  logic          fetch_last;
  logic [CW-1:0] res_col;
  logic [RW-1:0] res_row;
  logic          res_last;

  logic          res_en;
  logic          res_done;
  logic          zero_req;
  logic          pxl_en_reg;
  logic          src_mem_reg;
  logic [ZW-1:0] zero_cnt_reg;
  logic          out_valid_reg;
  logic [OP:0]   out_data_reg;

  // Conv results are only meaningful while a frame is in flight.
  assign res_en   = conv_valid && ((state_reg == FETCH) || (state_reg == FLUSH));
  assign res_done = res_en && res_last;

  // Read address generator: one raster position per FETCH cycle.
  raster_cnt #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (mem_rd),
    .col   (fetch_col),
    .row   (fetch_row),
    .last  (fetch_last)
  );

  // Result position tracker: one raster position per accepted conv strobe.
  raster_cnt #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_res_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (res_en),
    .col   (res_col),
    .row   (res_row),
    .last  (res_last)
  );

  assign mem_addr = mem_rd ? AW'(int'(fetch_row) * IMG_W + int'(fetch_col)) : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and control decode. Zero padding stops on the cycle the last
  // result is accepted, so no stray pixel is issued in FIN.
  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    zero_req   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (fetch_last) state_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (res_done || (zero_cnt_reg >= ZW'(NPIX))) state_next = FIN;
        else                                         zero_req   = 1'b1;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel stream strobes: a stream slot exists one cycle after every read
  // or zero request; src_mem selects memory data versus a zero pad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_en_reg  <= 1'b0;
      src_mem_reg <= 1'b0;
    end else begin
      pxl_en_reg  <= mem_rd | zero_req;
      src_mem_reg <= mem_rd;
    end
  end

  // mem_data is the memory's registered read port, valid in the cycle after
  // mem_rd, which is exactly the slot marked by pxl_en.
  assign pxl_out = src_mem_reg ? mem_data : '0;
  assign pxl_en  = pxl_en_reg;

  // Zero-pad counter, cleared whenever the sequencer is not flushing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   zero_cnt_reg <= '0;
    else if (state_reg != FLUSH)  zero_cnt_reg <= '0;
    else if (zero_req)            zero_cnt_reg <= zero_cnt_reg + ZW'(1);
  end

  // Result forwarding: pass interior results only, one cycle after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= res_en && (res_col >= CW'(K - 1)) && (res_row >= RW'(K - 1));
      out_data_reg  <= conv_in;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_conv_frame_seq.sv
// Scoreboard bench for conv_frame_seq: a default 32x32/K=5 instance and a
// small 8x6/K=3 instance, each with a pixel memory model (data = addr[7:0])
// and a conv stub that echoes the pixel stream with 3-cycle latency.
module tb_conv_frame_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- default instance ----------------
  logic       start, busy, done, mem_rd, pxl_en, conv_valid, out_valid;
  logic [9:0] mem_addr;
  logic [8:0] mem_data, pxl_out, conv_in, out_data;
  logic       stub_mute = 1'b0;
  logic [2:0] sv;
  logic [8:0] sd0, sd1, sd2;

  conv_frame_seq dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pxl_out(pxl_out), .pxl_en(pxl_en), .conv_in(conv_in),
    .conv_valid(conv_valid), .out_data(out_data), .out_valid(out_valid)
  );

  always @(posedge clk) if (mem_rd) mem_data <= {1'b0, mem_addr[7:0]};

  always @(posedge clk) begin
    if (!reset) begin
      sv <= '0; sd0 <= '0; sd1 <= '0; sd2 <= '0;
    end else begin
      sv  <= {sv[1:0], pxl_en};
      sd0 <= pxl_out; sd1 <= sd0; sd2 <= sd1;
    end
  end
  assign conv_valid = sv[2] & ~stub_mute;
  assign conv_in    = sd2;

  int addr_q[$];
  int exp_q[$];
  int rd_cnt, out_cnt, done_cnt, pen_cnt, first_val;
  int run_len, gap_len;
  bit chk_runs, run_seen;

  // Monitor: every read address and every forwarded result against the queues.
  always @(negedge clk) begin
    if (mem_rd) begin
      rd_cnt++;
      if (addr_q.size() == 0) check("mem_addr_extra", int'(mem_addr), -1);
      else check("mem_addr", int'(mem_addr), addr_q.pop_front());
    end
    if (pxl_en) pen_cnt++;
    if (done) done_cnt++;
    if (out_valid) begin
      if (out_cnt == 0) first_val = int'(out_data);
      out_cnt++;
      if (run_len == 0 && run_seen && chk_runs) check("run_gap", gap_len, 4);
      run_len++;
      gap_len = 0;
      if (exp_q.size() == 0) check("out_extra", int'(out_data), -1);
      else check("out_data", int'(out_data), exp_q.pop_front());
    end else begin
      if (run_len != 0) begin
        if (chk_runs) check("run_len", run_len, 28);
        run_seen = 1'b1;
      end
      run_len = 0;
      gap_len++;
    end
  end

  // ---------------- small instance ----------------
  logic       start_b, busy_b, done_b, mem_rd_b, pxl_en_b, conv_valid_b, out_valid_b;
  logic [5:0] mem_addr_b;
  logic [8:0] mem_data_b, pxl_out_b, conv_in_b, out_data_b;
  logic [2:0] sv_b;
  logic [8:0] sdb0, sdb1, sdb2;

  conv_frame_seq #(.IMG_W(8), .IMG_H(6), .K(3), .AW(6)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .pxl_out(pxl_out_b), .pxl_en(pxl_en_b), .conv_in(conv_in_b),
    .conv_valid(conv_valid_b), .out_data(out_data_b), .out_valid(out_valid_b)
  );

  always @(posedge clk) if (mem_rd_b) mem_data_b <= {3'b000, mem_addr_b};

  always @(posedge clk) begin
    if (!reset) begin
      sv_b <= '0; sdb0 <= '0; sdb1 <= '0; sdb2 <= '0;
    end else begin
      sv_b <= {sv_b[1:0], pxl_en_b};
      sdb0 <= pxl_out_b; sdb1 <= sdb0; sdb2 <= sdb1;
    end
  end
  assign conv_valid_b = sv_b[2];
  assign conv_in_b    = sdb2;

  int addr_qb[$];
  int exp_qb[$];
  int rd_b, out_b, done_cnt_b;

  always @(negedge clk) begin
    if (mem_rd_b) begin
      rd_b++;
      if (addr_qb.size() == 0) check("b_mem_addr_extra", int'(mem_addr_b), -1);
      else check("b_mem_addr", int'(mem_addr_b), addr_qb.pop_front());
    end
    if (done_b) done_cnt_b++;
    if (out_valid_b) begin
      out_b++;
      if (exp_qb.size() == 0) check("b_out_extra", int'(out_data_b), -1);
      else check("b_out_data", int'(out_data_b), exp_qb.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_frame(input bit with_results);
    for (int a = 0; a < 1024; a++) addr_q.push_back(a);
    if (with_results)
      for (int r = 4; r < 32; r++)
        for (int c = 4; c < 32; c++) exp_q.push_back((r * 32 + c) & 8'hFF);
  endtask

  task automatic clear_counts();
    rd_cnt = 0; out_cnt = 0; done_cnt = 0; pen_cnt = 0; first_val = -1;
    run_len = 0; gap_len = 0; run_seen = 1'b0;
  endtask

  // One full frame on the default instance; poke pulses start in FETCH and FIN.
  task automatic run_frame(input string tag, input bit mute, input int exp_outs, input bit poke);
    bit got = 1'b0;
    int busy_low = 0;
    clear_counts();
    stub_mute = mute;
    chk_runs  = !mute;
    push_frame(!mute);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 5000 && !got; cyc++) begin
      start = (poke && cyc == 10);
      if (done) begin
        got = 1'b1;
        check({tag, "_busy_at_done"}, int'(busy), 0);
        if (poke) start = 1'b1;
      end else if (!busy) begin
        busy_low++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, int'(got), 1);
    repeat (40) @(negedge clk);
    check({tag, "_reads"}, rd_cnt, 1024);
    check({tag, "_outputs"}, out_cnt, exp_outs);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_low"}, busy_low, 0);
    check({tag, "_addr_left"}, addr_q.size(), 0);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    if (!mute) check({tag, "_first_out"}, first_val, 'h84);
    else       check({tag, "_zero_pad_pixels"}, pen_cnt - 1024, 1024);
    $display("frame %s: reads=%0d outputs=%0d done=%0d pxl_en=%0d", tag, rd_cnt, out_cnt, done_cnt, pen_cnt);
    stub_mute = 1'b0;
  endtask

  initial begin
    int n;
    bit got;
    start = 1'b0;
    start_b = 1'b0;
    clear_counts();
    chk_runs = 1'b0;
    rd_b = 0; out_b = 0; done_cnt_b = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_pxl_en", int'(pxl_en), 0);
    check("rst_pxl_out", int'(pxl_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Full frame with ignored start pulses in FETCH and FIN.
    run_frame("main", 1'b0, 784, 1'b1);

    // Abandon a frame with an asynchronous reset at address 500.
    clear_counts();
    chk_runs = 1'b0;
    push_frame(1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_rd && mem_addr == 10'd500) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr_500", int'(mem_addr), 500);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_mem_rd", int'(mem_rd), 0);
    check("arst_mem_addr", int'(mem_addr), 0);
    check("arst_pxl_en", int'(pxl_en), 0);
    check("arst_pxl_out", int'(pxl_out), 0);
    check("arst_out_valid", int'(out_valid), 0);
    addr_q.delete();
    exp_q.delete();
    run_len = 0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abandoned_done", done_cnt, 0);
    $display("frame abandoned: reads=%0d outputs=%0d done=%0d", rd_cnt, out_cnt, done_cnt);

    // Fresh frame after the abandoned one.
    run_frame("restart", 1'b0, 784, 1'b0);

    // Conv never strobes: zero-pad cap forces completion.
    run_frame("hung_conv", 1'b1, 0, 1'b0);

    // Small geometry: 8x6 frame, K=3.
    for (int a = 0; a < 48; a++) addr_qb.push_back(a);
    for (int r = 2; r < 6; r++)
      for (int c = 2; c < 8; c++) exp_qb.push_back(r * 8 + c);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 1000 && !got; cyc++) begin
      if (done_b) got = 1'b1;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("b_done_seen", int'(got), 1);
    check("b_reads", rd_b, 48);
    check("b_outputs", out_b, 24);
    check("b_done_pulses", done_cnt_b, 1);
    check("b_exp_left", exp_qb.size(), 0);
    $display("frame small: reads=%0d outputs=%0d done=%0d", rd_b, out_b, done_cnt_b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_frame_seq.md
Name: conv_frame_seq

Overview:
- Frame sequencer for the first convolution layer.
- On a start pulse, reads one IMG_W x IMG_H frame in raster order from the input pixel memory and streams it into the conv layer.
- Feeds zero pixels after the frame so the conv pipeline drains.
- Tracks the raster position of each conv result and forwards only results whose K x K window lies fully inside the frame, i.e. (IMG_H-K+1) x (IMG_W-K+1) outputs, then signals done.

Parameters:
- IMG_W, 32, frame width in pixels.
- IMG_H, 32, frame height in pixels.
- K, 5, conv kernel size; border rows/cols to discard = K-1.
- PP, 8, pixel MSB index (pixels are PP+1 bits, signed).
- OP, 8, conv result MSB index (results are OP+1 bits, signed).
- AW, 10, memory address width; must satisfy 2^AW >= IMG_W*IMG_H.

Ports:
- clk, in, 1, single clock; everything is rising-edge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to process a frame; ignored unless in IDLE.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse after the final valid output.
- mem_rd, out, 1, pixel memory read strobe.
- mem_addr, out, AW, raster read address.
- mem_data, in, PP+1, read data, valid exactly 1 cycle after mem_rd.
- pxl_out, out, PP+1, pixel to the conv layer pxl_in.
- pxl_en, out, 1, conv advance enable; high on every cycle pxl_out carries a stream pixel.
- conv_in, in, OP+1, conv layer result.
- conv_valid, in, 1, conv result strobe; one strobe per stream position, in raster order.
- out_data, out, OP+1, forwarded result.
- out_valid, out, 1, high only for interior results.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters 0.
  - busy, done, mem_rd, pxl_en, out_valid = 0.
  - mem_addr, pxl_out, out_data = 0.
  - Reset mid-frame abandons the frame; no done pulse is generated.
- FSM states:
  - IDLE: on start=1 -> FETCH.
  - FETCH: mem_rd=1 and mem_addr increments 0..IMG_W*IMG_H-1, one per cycle. After the last address -> FLUSH.
  - FLUSH: mem_rd=0. Drives pxl_out=0 with pxl_en=1 until all results are received, then -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Fetch path:
  - pxl_out is registered mem_data.
  - pxl_en(t) = mem_rd(t-1) during FETCH/FLUSH transition, so each pixel reaches the conv exactly 1 cycle after its read.
  - There are no gaps in the stream.
- Result tracking:
  - res_col (0..IMG_W-1) and res_row (0..IMG_H-1) advance on each conv_valid; res_col wraps to 0 and increments res_row.
  - out_valid(t+1) = conv_valid(t) && res_col>=K-1 && res_row>=K-1.
  - out_data(t+1) = conv_in(t).
  - Result latency is 1 cycle from conv_valid.
- FLUSH exit: the cycle the result counter accepts position (IMG_H-1, IMG_W-1).
- Zero-pixel cap: FLUSH issues at most IMG_W*IMG_H zero pixels. If the cap is reached without completion, go to FIN anyway (done still pulses; protects against a hung conv).
- conv_valid outside FETCH/FLUSH is ignored: no counting, out_valid stays 0.
- start in any non-IDLE state: ignored, no queuing.
- start coinciding with the FIN cycle: ignored.
- Counts (defaults):
  - 1024 reads.
  - 784 out_valid pulses (28x28).
  - out_valid pulses come in 28 runs of 28; each run is separated by 4 low cycles of conv_valid-aligned gap.
- Widths: all counters are unsigned, sized by $clog2 of their range +1. No arithmetic is done on pixel data; data passes through unchanged and signed.

Decomposition:
- Shared package (cnn_pkg): IMG_W, IMG_H, K, PP, OP, and the state encoding (IDLE, FETCH, FLUSH, FIN as a 2-bit enum). These are also used by the pooling-layer sequencer.
- One sub-module, raster_cnt: a col/row counter with enable, wrap, and a last flag, parameterized by width/height. It is instantiated twice: once for the fetch address generation and once for result position tracking.

Test Plan:
- Reset, then start with the mem model returning data = addr[7:0] and a conv stub that echoes pxl_in with 3-cycle latency -> 1024 mem_rd cycles, addresses 0..1023. The first out_valid carries stub data for position (4,4) = 0x84. Exactly 784 out_valid pulses, then done for exactly 1 cycle; busy high throughout.
- Check row boundaries -> out_valid is low at positions (4,3) and (3,4), high at (4,4) and (31,31), and the row-5 run starts at col 4.
- Pulse start at cycle 10 of FETCH and again during FIN -> both ignored; a single done; the address sequence is unchanged.
- Assert reset=0 mid-frame at address 500, release, then start again -> outputs are 0 immediately (asynchronously). The next frame restarts at addr 0 and produces 784 outputs and one done.
- Conv stub that never asserts conv_valid -> FLUSH issues exactly 1024 zero pixels, then FIN, done=1, and zero out_valid pulses.
- Parameter override IMG_W=8, IMG_H=6, K=3 -> 48 reads, 24 outputs (4x6), done pulse.
